// File: rtl/arm_pipe_pkg.sv
// Shared encodings and helpers for the ARM pipeline hazard controller.
package arm_pipe_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b11;

  localparam logic [1:0] HZ_RUN   = 2'd0;
  localparam logic [1:0] HZ_STALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH = 2'd2;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0] rd;
    logic       reg_write;
    logic       mem_load;
  } stage_info;

  // Nearest in-flight producer wins; the PC is always read from the regfile path.
  function automatic logic [1:0] fwd_select(
    input logic [3:0] op,
    input logic       uses,
    input logic [3:0] ex_rd,
    input logic       ex_rw,
    input logic [3:0] mem_rd,
    input logic       mem_rw,
    input logic [3:0] wb_rd,
    input logic       wb_rw
  );
    logic [1:0] sel;
    if (!uses || (op == REG_PC)) begin
      sel = FWD_REGFILE;
    end else if (ex_rw && (ex_rd == op)) begin
      sel = FWD_EX;
    end else if (mem_rw && (mem_rd == op)) begin
      sel = FWD_MEM;
    end else if (wb_rw && (wb_rd == op)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB destination state, per-operand forward selects and load-use detect.
module hazard_scoreboard
  import arm_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_bubble,
  input  stage_info i_id,
  input  logic [3:0] i_rn,
  input  logic [3:0] i_rm,
  input  logic [3:0] i_rd,
  input  logic      i_uses_rn,
  input  logic      i_uses_rm,
  input  logic      i_uses_rd,
  output logic [1:0] o_fwd_rn_sel,
  output logic [1:0] o_fwd_rm_sel,
  output logic [1:0] o_fwd_rd_sel,
  output logic      o_load_use
);

  stage_info  r_ex;
  logic [3:0] r_mem_rd;
  logic       r_mem_rw;
  logic [3:0] r_wb_rd;
  logic       r_wb_rw;
  logic       w_ex_match;

  // Shadow regs keep advancing during a stall so the bubble flows down the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex     <= '0;
      r_mem_rd <= 4'd0;
      r_mem_rw <= 1'b0;
      r_wb_rd  <= 4'd0;
      r_wb_rw  <= 1'b0;
    end else begin
      r_ex     <= i_bubble ? stage_info'(6'd0) : i_id;
      r_mem_rd <= r_ex.rd;
      r_mem_rw <= r_ex.reg_write;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
    end
  end

  assign o_fwd_rn_sel = fwd_select(i_rn, i_uses_rn, r_ex.rd, r_ex.reg_write,
                                   r_mem_rd, r_mem_rw, r_wb_rd, r_wb_rw);
  assign o_fwd_rm_sel = fwd_select(i_rm, i_uses_rm, r_ex.rd, r_ex.reg_write,
                                   r_mem_rd, r_mem_rw, r_wb_rd, r_wb_rw);
  assign o_fwd_rd_sel = fwd_select(i_rd, i_uses_rd, r_ex.rd, r_ex.reg_write,
                                   r_mem_rd, r_mem_rw, r_wb_rd, r_wb_rw);

  assign w_ex_match = (i_uses_rn && (i_rn == r_ex.rd)) ||
                      (i_uses_rm && (i_rm == r_ex.rd)) ||
                      (i_uses_rd && (i_rd == r_ex.rd));
  assign o_load_use = r_ex.mem_load && (r_ex.rd != REG_PC) && w_ex_match;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// 5-stage ARM pipeline sequencer: forwarding, load-use stall, taken-branch flush
// and a saturating stall/flush event counter.
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_uses_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_load,
  input  logic             id_branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_bubble,
  output logic [1:0]       fwd_rn_sel,
  output logic [1:0]       fwd_rm_sel,
  output logic [1:0]       fwd_rd_sel,
  output logic [CNT_W-1:0] event_count
);

  localparam logic [1:0] STALL_EXTRA = 2'(LOAD_USE_STALLS - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_event_count;
  logic [1:0]       w_next_state;
  logic [1:0]       w_next_cnt;
  logic             w_stall;
  logic             w_flush;
  logic             w_load_use;
  logic [1:0]       w_fwd_rn;
  logic [1:0]       w_fwd_rm;
  logic [1:0]       w_fwd_rd;
  stage_info        w_id;

  assign w_id = {id_rd, id_reg_write, id_mem_load};

  hazard_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_bubble     (cu_bubble),
    .i_id         (w_id),
    .i_rn         (id_rn),
    .i_rm         (id_rm),
    .i_rd         (id_rd),
    .i_uses_rn    (id_uses_rn),
    .i_uses_rm    (id_uses_rm),
    .i_uses_rd    (id_uses_rd),
    .o_fwd_rn_sel (w_fwd_rn),
    .o_fwd_rm_sel (w_fwd_rm),
    .o_fwd_rd_sel (w_fwd_rd),
    .o_load_use   (w_load_use)
  );

  // Load-use outranks a taken branch; the branch stays in ID until the stall clears.
  always_comb begin
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_next_state = HZ_RUN;
    w_next_cnt   = r_cnt;
    case (r_state)
      HZ_RUN: begin
        if (w_load_use) begin
          w_stall      = 1'b1;
          w_next_cnt   = STALL_EXTRA;
          w_next_state = (STALL_EXTRA != 2'd0) ? HZ_STALL : HZ_RUN;
        end else if (id_branch_taken) begin
          w_flush      = 1'b1;
          w_next_state = HZ_FLUSH;
        end else begin
          w_next_state = HZ_RUN;
        end
      end
      HZ_STALL: begin
        w_stall      = 1'b1;
        w_next_cnt   = r_cnt - 2'd1;
        w_next_state = (r_cnt > 2'd1) ? HZ_STALL : HZ_RUN;
      end
      HZ_FLUSH: begin
        w_next_state = HZ_RUN;
      end
      default: begin
        w_next_state = HZ_RUN;
        w_next_cnt   = 2'd0;
      end
    endcase
  end

  assign pc_enable    = reset & ~w_stall;
  assign if_id_enable = reset & ~w_stall;
  assign if_id_flush  = reset & w_flush;
  assign cu_bubble    = ~reset | w_stall;
  assign fwd_rn_sel   = reset ? w_fwd_rn : FWD_REGFILE;
  assign fwd_rm_sel   = reset ? w_fwd_rm : FWD_REGFILE;
  assign fwd_rd_sel   = reset ? w_fwd_rd : FWD_REGFILE;
  assign event_count  = r_event_count;

  // Hazard state and saturating event counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= HZ_RUN;
      r_cnt         <= 2'd0;
      r_event_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if ((cu_bubble || if_id_flush) && (r_event_count != {CNT_W{1'b1}})) begin
        r_event_count <= r_event_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (1-stall/16-bit and 2-stall/3-bit
// counter) share stimulus and are checked every cycle against an instruction-history model.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] id_rn = 4'd0, id_rm = 4'd0, id_rd = 4'd0;
  logic       id_uses_rn = 1'b0, id_uses_rm = 1'b0, id_uses_rd = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_load = 1'b0, id_branch_taken = 1'b0;

  logic        a_pc [2];
  logic        a_en [2];
  logic        a_fl [2];
  logic        a_bub[2];
  logic [1:0]  a_frn[2];
  logic [1:0]  a_frm[2];
  logic [1:0]  a_frd[2];
  logic [15:0] ec0;
  logic [2:0]  ec1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LOAD_USE_STALLS(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd),
    .id_reg_write(id_reg_write), .id_mem_load(id_mem_load), .id_branch_taken(id_branch_taken),
    .pc_enable(a_pc[0]), .if_id_enable(a_en[0]), .if_id_flush(a_fl[0]), .cu_bubble(a_bub[0]),
    .fwd_rn_sel(a_frn[0]), .fwd_rm_sel(a_frm[0]), .fwd_rd_sel(a_frd[0]), .event_count(ec0)
  );

  pipeline_hazard_controller #(.LOAD_USE_STALLS(2), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd),
    .id_reg_write(id_reg_write), .id_mem_load(id_mem_load), .id_branch_taken(id_branch_taken),
    .pc_enable(a_pc[1]), .if_id_enable(a_en[1]), .if_id_flush(a_fl[1]), .cu_bubble(a_bub[1]),
    .fwd_rn_sel(a_frn[1]), .fwd_rm_sel(a_frm[1]), .fwd_rd_sel(a_frd[1]), .event_count(ec1)
  );

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [3:0] rd; logic rw; logic ld; } instr_t;
  instr_t h [2][3];   // [dut][0=EX,1=MEM,2=WB] instructions in flight
  int     stall_left[2];
  bit     in_flush[2];
  int     cnt[2];
  int     lus[2]  = '{1, 2};
  int     cmax[2] = '{65535, 7};

  function automatic int fsel(input int k, input logic [3:0] op, input logic u);
    int s;
    s = 0;
    if (u && op != 4'd15)
      for (int i = 2; i >= 0; i--)
        if (h[k][i].rw && h[k][i].rd == op) s = i + 1;
    return s;
  endfunction

  initial begin
    instr_t nh [2][3];
    int     nsl[2];
    bit     nfp[2];
    int     ncnt[2];
    bit     lu, stall, flush;
    int     e_pc, e_en, e_fl, e_bub, e_rn, e_rm, e_rd, e_cnt, a_cnt;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) h[k][s] = '0;
      stall_left[k] = 0; in_flush[k] = 1'b0; cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        lu = h[k][0].ld && h[k][0].rd != 4'd15 &&
             ((id_uses_rn && id_rn == h[k][0].rd) ||
              (id_uses_rm && id_rm == h[k][0].rd) ||
              (id_uses_rd && id_rd == h[k][0].rd));
        stall = 1'b0; flush = 1'b0;
        if (stall_left[k] > 0) stall = 1'b1;
        else if (!in_flush[k]) begin
          if (lu) stall = 1'b1;
          else if (id_branch_taken) flush = 1'b1;
        end
        if (!reset) begin
          e_pc = 0; e_en = 0; e_fl = 0; e_bub = 1; e_rn = 0; e_rm = 0; e_rd = 0; e_cnt = 0;
        end else begin
          e_pc = !stall; e_en = !stall; e_fl = flush; e_bub = stall;
          e_rn = fsel(k, id_rn, id_uses_rn);
          e_rm = fsel(k, id_rm, id_uses_rm);
          e_rd = fsel(k, id_rd, id_uses_rd);
          e_cnt = cnt[k];
        end
        a_cnt = (k == 0) ? int'(ec0) : int'(ec1);
        chk("pc_enable",    k, int'(a_pc[k]),  e_pc);
        chk("if_id_enable", k, int'(a_en[k]),  e_en);
        chk("if_id_flush",  k, int'(a_fl[k]),  e_fl);
        chk("cu_bubble",    k, int'(a_bub[k]), e_bub);
        chk("fwd_rn_sel",   k, int'(a_frn[k]), e_rn);
        chk("fwd_rm_sel",   k, int'(a_frm[k]), e_rm);
        chk("fwd_rd_sel",   k, int'(a_frd[k]), e_rd);
        chk("event_count",  k, a_cnt,          e_cnt);
        nh[k][2] = h[k][1];
        nh[k][1] = h[k][0];
        nh[k][0] = stall ? instr_t'(6'd0) : instr_t'({id_rd, id_reg_write, id_mem_load});
        if (stall_left[k] > 0) nsl[k] = stall_left[k] - 1;
        else if (stall) nsl[k] = lus[k] - 1;
        else nsl[k] = 0;
        nfp[k]  = flush;
        ncnt[k] = cnt[k] + ((stall || flush) ? 1 : 0);
        if (ncnt[k] > cmax[k]) ncnt[k] = cmax[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          for (int s = 0; s < 3; s++) h[k][s] = '0;
          stall_left[k] = 0; in_flush[k] = 1'b0; cnt[k] = 0;
        end else begin
          for (int s = 0; s < 3; s++) h[k][s] = nh[k][s];
          stall_left[k] = nsl[k]; in_flush[k] = nfp[k]; cnt[k] = ncnt[k];
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [3:0] rn, rm, rd, input logic urn, urm, urd, rw, ld, br);
    @(posedge clk); #1;
    id_rn = rn; id_rm = rm; id_rd = rd;
    id_uses_rn = urn; id_uses_rm = urm; id_uses_rd = urd;
    id_reg_write = rw; id_mem_load = ld; id_branch_taken = br;
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset held for three cycles, then release
    for (int i = 0; i < 3; i++) begin
      nops(1);
      chk("rst_pc_enable", 0, int'(a_pc[0]), 0);
      chk("rst_cu_bubble", 0, int'(a_bub[0]), 1);
      chk("rst_event_count", 0, int'(ec0), 0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("release_pc_enable", 0, int'(a_pc[0]), 1);
    nops(2);

    // 2: forwarding from EX, MEM, WB, then regfile; R15 never forwarded
    cyc(4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fwd_rn_ex", 0, int'(a_frn[0]), 1);
    cyc(4'd0, 4'd5, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fwd_rm_mem", 0, int'(a_frm[0]), 2);
    cyc(4'd0, 4'd5, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fwd_rm_wb", 0, int'(a_frm[0]), 3);
    cyc(4'd0, 4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fwd_rm_rf", 0, int'(a_frm[0]), 0);
    cyc(4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4'd15, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_fwd_r15", 0, int'(a_frn[0]), 0);
    nops(3);

    // 3/4: LDRB R2 then STR R2 (held in ID while stalled)
    cyc(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_lu_pc_enable", 0, int'(a_pc[0]), 0);
    chk("lit_lu_bubble", 0, int'(a_bub[0]), 1);
    cyc(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_lu_resume", 0, int'(a_pc[0]), 1);
    chk("lit_lu_fwd_mem", 0, int'(a_frd[0]), 2);
    chk("lit_lu_count", 0, int'(ec0), 1);
    chk("lit_lu2_still", 1, int'(a_pc[1]), 0);
    cyc(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_lu2_resume", 1, int'(a_pc[1]), 1);
    chk("lit_lu2_fwd_wb", 1, int'(a_frd[1]), 3);
    chk("lit_lu2_count", 1, int'(ec1), 2);
    nops(3);

    // 5: taken branch flushes once; the repeat in FLUSH is ignored
    cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_br_flush", 0, int'(a_fl[0]), 1);
    cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_br_ignored", 0, int'(a_fl[0]), 0);
    nops(1);
    chk("lit_br_count", 0, int'(ec0), 2);
    nops(2);

    // 6: load-use together with a taken branch
    cyc(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lit_lubr_stall", 0, int'(a_bub[0]), 1);
    chk("lit_lubr_noflush", 0, int'(a_fl[0]), 0);
    cyc(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lit_lubr_flush", 0, int'(a_fl[0]), 1);
    chk("lit_lubr_enable", 0, int'(a_en[0]), 1);
    cyc(4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lit_lubr2_flush", 1, int'(a_fl[1]), 1);
    nops(3);

    // counter saturation on the narrow instance
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      nops(1);
    end
    nops(1);
    chk("lit_sat_count", 1, int'(ec1), 7);
    chk("lit_wide_count", 0, int'(ec0), 7);

    // reset in the middle of a STALL
    cyc(4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("lit_mid_rst_pc", 1, int'(a_pc[1]), 0);
    chk("lit_mid_rst_bubble", 1, int'(a_bub[1]), 1);
    chk("lit_mid_rst_count", 1, int'(ec1), 0);
    nops(1);
    @(posedge clk); #1;
    reset = 1'b1;
    id_rm = 4'd0; id_uses_rm = 1'b0;
    @(negedge clk);
    chk("lit_after_rst_pc", 1, int'(a_pc[1]), 1);
    chk("lit_after_rst_bubble", 1, int'(a_bub[1]), 0);
    nops(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
